// File: rtl/day8_pkg.sv
// Shared defaults and FSM encoding for the circuit merge controller.
package day8_pkg;

  localparam int NUM_ELEMENT_DEF = 20;
  localparam int NUM_EDGES_DEF   = 10;
  localparam int IDX_W_DEF       = 10;
  localparam int SIZE_W_DEF      = 10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_WAIT_EDGE,
    ST_FIND_SRC,
    ST_FIND_DST,
    ST_UNION,
    ST_SCAN,
    ST_MULT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/circuit_merge_ctrl_if.sv
// Control, edge-stream handshake and status bundle of the merge controller.
interface circuit_merge_ctrl_if #(
  parameter int IDX_W = 10
);

  logic             start;
  logic             edge_valid;
  logic             edge_ready;
  logic [IDX_W-1:0] edge_src;
  logic [IDX_W-1:0] edge_dst;
  logic             busy;
  logic             finished;
  logic [31:0]      result;
  logic [IDX_W-1:0] merges;
  logic             error;

  modport master (
    output start, edge_valid, edge_src, edge_dst,
    input  edge_ready, busy, finished, result, merges, error
  );

  modport slave (
    input  start, edge_valid, edge_src, edge_dst,
    output edge_ready, busy, finished, result, merges, error
  );

endinterface

// File: rtl/top3_insert.sv
// Keeps the three largest values seen so far, sorted top0 >= top1 >= top2.
// Empty slots hold 1 so the product of all three is always meaningful.
module top3_insert import day8_pkg::*; #(
  parameter int SIZE_W = SIZE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              ins_en,
  input  logic [SIZE_W-1:0] ins_val,
  output logic [SIZE_W-1:0] top0,
  output logic [SIZE_W-1:0] top1,
  output logic [SIZE_W-1:0] top2
);

  localparam logic [SIZE_W-1:0] EMPTY = SIZE_W'(1);

  logic [SIZE_W-1:0] top0_reg, top1_reg, top2_reg;
  logic [SIZE_W-1:0] top0_next, top1_next, top2_next;

  // Compare the new value against each slot and shift the smaller ones down.
  always_comb begin
    top0_next = top0_reg;
    top1_next = top1_reg;
    top2_next = top2_reg;
    if (clr) begin
      top0_next = EMPTY;
      top1_next = EMPTY;
      top2_next = EMPTY;
    end else if (ins_en) begin
      if (ins_val > top0_reg) begin
        top0_next = ins_val;
        top1_next = top0_reg;
        top2_next = top1_reg;
      end else if (ins_val > top1_reg) begin
        top1_next = ins_val;
        top2_next = top1_reg;
      end else if (ins_val > top2_reg) begin
        top2_next = ins_val;
      end
    end
  end

  // Slot registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      top0_reg <= EMPTY;
      top1_reg <= EMPTY;
      top2_reg <= EMPTY;
    end else begin
      top0_reg <= top0_next;
      top1_reg <= top1_next;
      top2_reg <= top2_next;
    end
  end

  assign top0 = top0_reg;
  assign top1 = top1_reg;
  assign top2 = top2_reg;

endmodule

// File: rtl/circuit_merge_ctrl.sv
// Union-find over a stream of sorted edges; reports the product of the
// three largest resulting circuit sizes and the number of successful unions.
module circuit_merge_ctrl import day8_pkg::*; #(
  parameter int NUM_ELEMENT = NUM_ELEMENT_DEF,
  parameter int NUM_EDGES   = NUM_EDGES_DEF,
  parameter int IDX_W       = IDX_W_DEF,
  parameter int SIZE_W      = SIZE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  circuit_merge_ctrl_if.slave bus
);

  localparam int MEM_AW = (NUM_ELEMENT > 1) ? $clog2(NUM_ELEMENT) : 1;
  localparam int CNT_W  = $clog2(NUM_EDGES + 1);
  localparam logic [MEM_AW-1:0] LAST_IDX = MEM_AW'(NUM_ELEMENT - 1);

  state_t state_reg, state_next;

  logic [MEM_AW-1:0] idx_reg, cur_reg, dst_reg, root_src_reg, root_dst_reg;
  logic [CNT_W-1:0]  edge_cnt_reg;
  logic [IDX_W-1:0]  merges_reg;
  logic              error_reg;
  logic [31:0]       result_reg;

  // Forest storage; not reset, INIT rebuilds it at the start of every run.
  logic [MEM_AW-1:0] parent_mem [NUM_ELEMENT];
  logic [SIZE_W-1:0] size_mem   [NUM_ELEMENT];

  logic              par_we, size_we;
  logic [MEM_AW-1:0] par_waddr, par_wdata, size_waddr;
  logic [SIZE_W-1:0] size_wdata;

  logic [SIZE_W-1:0] top0, top1, top2;

  logic start_ok, xfer, oob, cur_is_root, scan_is_root, roots_differ, last_xfer;
  logic [MEM_AW-1:0] cur_parent;
  logic [SIZE_W-1:0] size_src, size_dst, size_sum;

  assign start_ok     = bus.start && (state_reg == ST_IDLE || state_reg == ST_DONE);
  assign xfer         = (state_reg == ST_WAIT_EDGE) && bus.edge_valid;
  assign oob          = (bus.edge_src >= IDX_W'(NUM_ELEMENT)) || (bus.edge_dst >= IDX_W'(NUM_ELEMENT));
  assign last_xfer    = (edge_cnt_reg == CNT_W'(NUM_EDGES - 1));
  assign cur_parent   = parent_mem[cur_reg];
  assign cur_is_root  = (cur_parent == cur_reg);
  assign scan_is_root = (parent_mem[idx_reg] == idx_reg);
  assign roots_differ = (root_src_reg != root_dst_reg);
  assign size_src     = size_mem[root_src_reg];
  assign size_dst     = size_mem[root_dst_reg];
  assign size_sum     = size_src + size_dst;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic and forest write strobes.
  always_comb begin
    state_next = state_reg;
    par_we     = 1'b0;
    par_waddr  = '0;
    par_wdata  = '0;
    size_we    = 1'b0;
    size_waddr = '0;
    size_wdata = '0;
    case (state_reg)
      ST_IDLE, ST_DONE: if (bus.start) state_next = ST_INIT;
      ST_INIT: begin
        par_we     = 1'b1;
        par_waddr  = idx_reg;
        par_wdata  = idx_reg;
        size_we    = 1'b1;
        size_waddr = idx_reg;
        size_wdata = SIZE_W'(1);
        if (idx_reg == LAST_IDX) state_next = ST_WAIT_EDGE;
      end
      ST_WAIT_EDGE: begin
        // A bad endpoint still consumes an edge slot; if it was the last
        // one, go straight to the scan rather than waiting forever.
        if (xfer) begin
          if (!oob)           state_next = ST_FIND_SRC;
          else if (last_xfer) state_next = ST_SCAN;
        end
      end
      ST_FIND_SRC: if (cur_is_root) state_next = ST_FIND_DST;
      ST_FIND_DST: if (cur_is_root) state_next = ST_UNION;
      ST_UNION: begin
        // Smaller tree goes under the larger; on a tie dst joins src.
        if (roots_differ) begin
          par_we  = 1'b1;
          size_we = 1'b1;
          size_wdata = size_sum;
          if (size_src < size_dst) begin
            par_waddr  = root_src_reg;
            par_wdata  = root_dst_reg;
            size_waddr = root_dst_reg;
          end else begin
            par_waddr  = root_dst_reg;
            par_wdata  = root_src_reg;
            size_waddr = root_src_reg;
          end
        end
        state_next = (edge_cnt_reg == CNT_W'(NUM_EDGES)) ? ST_SCAN : ST_WAIT_EDGE;
      end
      ST_SCAN: if (idx_reg == LAST_IDX) state_next = ST_MULT;
      ST_MULT: state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Forest write port.
  always_ff @(posedge clk) begin
    if (par_we)  parent_mem[par_waddr] <= par_wdata;
    if (size_we) size_mem[size_waddr]  <= size_wdata;
  end

  // Datapath registers: walk pointer, roots, counters and result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_reg      <= '0;
      cur_reg      <= '0;
      dst_reg      <= '0;
      root_src_reg <= '0;
      root_dst_reg <= '0;
      edge_cnt_reg <= '0;
      merges_reg   <= '0;
      error_reg    <= 1'b0;
      result_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            idx_reg      <= '0;
            edge_cnt_reg <= '0;
            merges_reg   <= '0;
            error_reg    <= 1'b0;
            result_reg   <= '0;
          end
        end
        ST_INIT, ST_SCAN: idx_reg <= (idx_reg == LAST_IDX) ? '0 : idx_reg + MEM_AW'(1);
        ST_WAIT_EDGE: begin
          if (xfer) begin
            edge_cnt_reg <= edge_cnt_reg + CNT_W'(1);
            if (oob) begin
              error_reg <= 1'b1;
            end else begin
              cur_reg <= bus.edge_src[MEM_AW-1:0];
              dst_reg <= bus.edge_dst[MEM_AW-1:0];
            end
          end
        end
        ST_FIND_SRC: begin
          if (cur_is_root) begin
            root_src_reg <= cur_reg;
            cur_reg      <= dst_reg;
          end else begin
            cur_reg <= cur_parent;
          end
        end
        ST_FIND_DST: begin
          if (cur_is_root) root_dst_reg <= cur_reg;
          else             cur_reg      <= cur_parent;
        end
        ST_UNION: if (roots_differ) merges_reg <= merges_reg + IDX_W'(1);
        ST_MULT:  result_reg <= 32'(top0) * 32'(top1) * 32'(top2);
        default: ;
      endcase
    end
  end

  top3_insert #(.SIZE_W(SIZE_W)) u_top3 (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_ok),
    .ins_en  ((state_reg == ST_SCAN) && scan_is_root),
    .ins_val (size_mem[idx_reg]),
    .top0    (top0),
    .top1    (top1),
    .top2    (top2)
  );

  assign bus.edge_ready = (state_reg == ST_WAIT_EDGE);
  assign bus.busy       = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
  assign bus.finished   = (state_reg == ST_DONE);
  assign bus.result     = result_reg;
  assign bus.merges     = merges_reg;
  assign bus.error      = error_reg;

endmodule
